// File: rtl/muldiv_pkg.sv
// Shared types for the multi-cycle multiply/divide unit: FSM states, op kinds, default width.
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } muldivStateT;

    typedef enum logic [1:0] {
        OP_MUL = 2'd0,
        OP_DIV = 2'd1,
        OP_MOD = 2'd2
    } opKindT;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiplier or the restoring divider (purely combinational).
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             divMode,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] regA,
    input  logic [WIDTH-1:0] regB,
    output logic [WIDTH-1:0] accNext,
    output logic [WIDTH-1:0] regANext,
    output logic [WIDTH-1:0] regBNext
);

    // In divide mode acc is the partial remainder, regA the dividend/quotient, regB the divisor.
    logic [WIDTH:0] remShift;
    logic [WIDTH:0] remDiff;

    always_comb begin
        remShift = {acc, regA[WIDTH-1]};
        remDiff  = remShift - {1'b0, regB};
        accNext  = acc;
        regANext = regA;
        regBNext = regB;
        if (divMode) begin
            if (remShift >= {1'b0, regB}) begin
                accNext  = remDiff[WIDTH-1:0];
                regANext = {regA[WIDTH-2:0], 1'b1};
            end else begin
                accNext  = remShift[WIDTH-1:0];
                regANext = {regA[WIDTH-2:0], 1'b0};
            end
        end else begin
            accNext  = regB[0] ? acc + regA : acc;
            regANext = regA << 1;
            regBNext = regB >> 1;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide/modulo controller for the execute stage; stalls the pipeline
// while an operation iterates and returns the result with a one-cycle done pulse.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             isMul,
    input  logic             isDiv,
    input  logic             isMod,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             stall_req,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);

    muldivStateT      state;
    muldivStateT      stateNext;
    opKindT           kind;
    opKindT           acceptKind;
    logic             accept;
    logic             lastIter;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] regA;
    logic [WIDTH-1:0] regB;
    logic [WIDTH-1:0] stepAcc;
    logic [WIDTH-1:0] stepA;
    logic [WIDTH-1:0] stepB;
    logic [WIDTH-1:0] resultR;
    logic             divByZeroR;

    muldiv_step #(.WIDTH(WIDTH)) uStep (
        .divMode  (kind != OP_MUL),
        .acc      (acc),
        .regA     (regA),
        .regB     (regB),
        .accNext  (stepAcc),
        .regANext (stepA),
        .regBNext (stepB)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext  = state;
        accept     = 1'b0;
        lastIter   = (cnt == CNT_W'(WIDTH - 1));
        acceptKind = isMul ? OP_MUL : (isDiv ? OP_DIV : OP_MOD);
        case (state)
            IDLE: begin
                if (start && (isMul || isDiv || isMod)) begin
                    accept = 1'b1;
                    if (isMul) begin
                        stateNext = MUL;
                    end else if (op_b == '0) begin
                        stateNext = DONE;
                    end else begin
                        stateNext = DIV;
                    end
                end
            end
            MUL, DIV: begin
                if (lastIter) begin
                    stateNext = DONE;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Multiply and divide share the operand registers: acc starts at 0, A/B take op_a/op_b.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kind       <= OP_MUL;
            cnt        <= '0;
            acc        <= '0;
            regA       <= '0;
            regB       <= '0;
            resultR    <= '0;
            divByZeroR <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        kind <= acceptKind;
                        cnt  <= '0;
                        acc  <= '0;
                        regA <= op_a;
                        regB <= op_b;
                        if (!isMul && op_b == '0) begin
                            resultR    <= (acceptKind == OP_DIV) ? '1 : op_a;
                            divByZeroR <= 1'b1;
                        end
                    end
                end
                MUL, DIV: begin
                    acc  <= stepAcc;
                    regA <= stepA;
                    regB <= stepB;
                    cnt  <= cnt + 1'b1;
                    if (lastIter) begin
                        resultR <= (kind == OP_DIV) ? stepA : stepAcc;
                    end
                end
                default: begin
                    divByZeroR <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign stall_req   = (start && accept) || busy;
    assign result      = resultR;
    assign div_by_zero = divByZeroR;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer against a plain-arithmetic reference.
module tb_muldiv_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        isMul;
    logic        isDiv;
    logic        isMod;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        stall_req;
    logic        done;
    logic [31:0] result;
    logic        div_by_zero;

    int nTests = 0;
    int nFail  = 0;

    muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .isMul       (isMul),
        .isDiv       (isDiv),
        .isMod       (isMod),
        .op_a        (op_a),
        .op_b        (op_b),
        .busy        (busy),
        .stall_req   (stall_req),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nTests++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned arithmetic, flag priority mul > div > mod, div-by-zero rules.
    task automatic refModel(input logic m, input logic d, input logic [31:0] a,
                            input logic [31:0] b, output logic [31:0] res,
                            output logic dbz, output int lat);
        logic [63:0] prod;
        prod = {32'd0, a} * {32'd0, b};
        dbz  = 1'b0;
        lat  = 33;
        if (m) begin
            res = prod[31:0];
        end else if (b == 32'd0) begin
            res = d ? 32'hFFFF_FFFF : a;
            dbz = 1'b1;
            lat = 1;
        end else begin
            res = d ? a / b : a % b;
        end
    endtask

    task automatic runOp(input logic m, input logic d, input logic md,
                         input logic [31:0] a, input logic [31:0] b,
                         input bit inject, input string tag);
        logic [31:0] expRes;
        logic        expDbz;
        int          expLat;
        logic [31:0] gotRes;
        logic        gotDbz;
        int          k;
        int          busyCnt;
        bit          got;
        refModel(m, d, a, b, expRes, expDbz, expLat);
        @(negedge clk);
        start = 1'b1; isMul = m; isDiv = d; isMod = md; op_a = a; op_b = b;
        #1;
        checkVal({tag, ".stall"}, 64'(stall_req), 64'd1);
        k = 0; busyCnt = 0; got = 1'b0; gotRes = '0; gotDbz = 1'b0;
        while (!got && k < 100) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            if (busy) busyCnt++;
            if (done) begin
                got    = 1'b1;
                gotRes = result;
                gotDbz = div_by_zero;
            end
            op_a = $urandom; op_b = $urandom;
            isMul = 1'($urandom); isDiv = 1'($urandom); isMod = 1'($urandom);
            if (inject && (k == 5 || done)) begin
                start = 1'b1; isMul = 1'b1;
            end
        end
        checkVal({tag, ".latency"}, 64'(k), 64'(expLat));
        checkVal({tag, ".result"}, 64'(gotRes), 64'(expRes));
        checkVal({tag, ".dbz"}, 64'(gotDbz), 64'(expDbz));
        checkVal({tag, ".busyCycles"}, 64'(busyCnt), 64'(expLat));
        @(negedge clk);
        start = 1'b0; isMul = 1'b0; isDiv = 1'b0; isMod = 1'b0;
        #1;
        checkVal({tag, ".doneAfter"}, 64'(done), 64'd0);
        checkVal({tag, ".busyAfter"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rm;
        logic        rd;
        logic        rmd;
        bit          sawDone;
        rst = 1'b1; start = 1'b0; isMul = 1'b0; isDiv = 1'b0; isMod = 1'b0;
        op_a = '0; op_b = '0;
        #3;
        checkVal("reset.busy", 64'(busy), 64'd0);
        checkVal("reset.done", 64'(done), 64'd0);
        checkVal("reset.result", 64'(result), 64'd0);
        checkVal("reset.dbz", 64'(div_by_zero), 64'd0);
        checkVal("reset.stall", 64'(stall_req), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        runOp(1, 0, 0, 32'd7, 32'd6, 0, "mul7x6");
        runOp(1, 0, 0, 32'hFFFF_FFFF, 32'd2, 0, "mulOvf");
        runOp(1, 1, 0, 32'd3, 32'd5, 0, "mulPrio");
        runOp(0, 1, 0, 32'd100, 32'd7, 0, "div100_7");
        runOp(0, 0, 1, 32'd100, 32'd7, 0, "mod100_7");
        runOp(0, 1, 0, 32'd5, 32'd9, 0, "div5_9");
        runOp(0, 0, 1, 32'd5, 32'd9, 0, "mod5_9");
        runOp(0, 1, 0, 32'd55, 32'd0, 0, "div0");
        runOp(0, 0, 1, 32'd55, 32'd0, 0, "mod0");
        runOp(0, 1, 1, 32'hFFFF_FFFF, 32'd1, 0, "divPrio");
        runOp(1, 0, 0, 32'd12345, 32'd678, 1, "mulInject");

        // start with no operation flag must be ignored
        @(negedge clk);
        start = 1'b1; op_a = 32'd1; op_b = 32'd1;
        #1;
        checkVal("noFlag.stall", 64'(stall_req), 64'd0);
        @(negedge clk);
        start = 1'b0;
        checkVal("noFlag.busy", 64'(busy), 64'd0);

        for (int i = 0; i < 30; i++) begin
            rm  = 1'($urandom);
            rd  = 1'($urandom);
            rmd = ~rm & ~rd ? 1'b1 : 1'($urandom);
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 255);
                default: rb = $urandom;
            endcase
            runOp(rm, rd, rmd, ra, rb, 0, $sformatf("rand%0d", i));
        end

        // asynchronous reset in the middle of a divide aborts it
        @(negedge clk);
        start = 1'b1; isDiv = 1'b1; op_a = 32'd100000; op_b = 32'd3;
        @(negedge clk);
        start = 1'b0; isDiv = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkVal("midRst.busy", 64'(busy), 64'd0);
        checkVal("midRst.done", 64'(done), 64'd0);
        checkVal("midRst.result", 64'(result), 64'd0);
        checkVal("midRst.dbz", 64'(div_by_zero), 64'd0);
        checkVal("midRst.stall", 64'(stall_req), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        sawDone = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) sawDone = 1'b1;
        end
        checkVal("midRst.noDone", 64'(sawDone), 64'd0);
        runOp(1, 0, 0, 32'd9, 32'd9, 0, "mul9x9");

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
